// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the multi-port register file.
//   OPC_STORE / F3_*  : opcode and funct3 encodings that select store formatting
//   store_fmt_e       : byte / half / word store data format
//   decode_store_fmt  : maps {funct3, opcode} to a store_fmt_e
package regfile_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_SW     = 3'b010;

    typedef enum logic [1:0] {
        FMT_B = 2'd0,
        FMT_H = 2'd1,
        FMT_W = 2'd2
    } store_fmt_e;

    // Anything that is not a byte/half store passes the word through unchanged.
    function automatic store_fmt_e decode_store_fmt(input logic [2:0] funct3,
                                                    input logic [6:0] opcode);
        store_fmt_e fmt;
        fmt = FMT_W;
        if (opcode == OPC_STORE) begin
            case (funct3)
                F3_SB:   fmt = FMT_B;
                F3_SH:   fmt = FMT_H;
                F3_SW:   fmt = FMT_W;
                default: fmt = FMT_W;
            endcase
        end else begin
            fmt = FMT_W;
        end
        return fmt;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write tracking for the hazard unit.
//   clk, rst        : clock, async active-high reset
//   wr_legal        : a legal write to wr_dest happens this cycle (clears busy)
//   wr_dest         : writeback destination
//   set_en/set_dest : mark a register pending (new long-latency producer)
//   rd_addr         : packed read addresses, one per read port
//   rd_busy         : per-port pending flag, hidden when the same-cycle write resolves it
//   busy_count      : registered number of pending registers
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int NUM_RD_PORTS  = 2,
    parameter int ZERO_REG_EN   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_legal,
    input  logic [ADDRESS_WIDTH-1:0]              wr_dest,
    input  logic                                  set_en,
    input  logic [ADDRESS_WIDTH-1:0]              set_dest,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS-1:0]               rd_busy,
    output logic [ADDRESS_WIDTH:0]                busy_count
);

    logic [NUM_REGS-1:0]    busy_q;
    logic [NUM_REGS-1:0]    busy_d;
    logic [ADDRESS_WIDTH:0] count_q;
    logic [ADDRESS_WIDTH:0] count_d;
    logic [NUM_RD_PORTS-1:0] rd_busy_s;

    // Next busy vector (set beats clear) and its population count.
    always_comb begin
        busy_d  = busy_q;
        count_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (set_en && (set_dest == ADDRESS_WIDTH'(r)) && !((ZERO_REG_EN != 0) && (r == 0))) begin
                busy_d[r] = 1'b1;
            end else if (wr_legal && (wr_dest == ADDRESS_WIDTH'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            count_d = count_d + (ADDRESS_WIDTH+1)'(busy_d[r]);
        end
    end

    // Busy bits and count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Per-port busy lookup; out-of-range addresses never match and read as idle.
    always_comb begin
        rd_busy_s = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rd_busy_s[p] = rd_busy_s[p] |
                    (busy_q[r] && (rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ADDRESS_WIDTH'(r)));
            end
            // A write landing on this register this cycle is bypassed, so no stall.
            rd_busy_s[p] = rd_busy_s[p] &&
                !(wr_legal && (wr_dest == rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]));
        end
    end

    assign rd_busy    = rd_busy_s;
    assign busy_count = count_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file.
//   clk, rst             : clock, async active-high reset
//   wr_en/wr_dest/wr_data: writeback port (posedge write, same-cycle bypass)
//   rd_addr / rd_data    : packed combinational read ports, port p at [p*W +: W]
//   rd_busy              : per-port pending-producer flag
//   sb_set_en/sb_set_dest: mark a register pending at issue
//   funct3, opcode       : select byte/half/word formatting of read port 1
//   st_data              : formatted store data
//   busy_count           : number of registers currently pending
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int NUM_RD_PORTS  = 2,
    parameter int ZERO_REG_EN   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [ADDRESS_WIDTH-1:0]              wr_dest,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD_PORTS-1:0]               rd_busy,
    input  logic                                  sb_set_en,
    input  logic [ADDRESS_WIDTH-1:0]              sb_set_dest,
    input  logic [2:0]                            funct3,
    input  logic [6:0]                            opcode,
    output logic [DATA_WIDTH-1:0]                 st_data,
    output logic [ADDRESS_WIDTH:0]                busy_count
);

    logic [DATA_WIDTH-1:0]    regs_q  [NUM_REGS];
    logic [DATA_WIDTH-1:0]    regs_d  [NUM_REGS];
    logic [DATA_WIDTH-1:0]    rd_word_s [NUM_RD_PORTS];
    logic                     wr_legal_s;
    logic [DATA_WIDTH-1:0]    st_data_s;
    store_fmt_e               fmt_s;

    // A write is legal when it targets an existing, writable register outside reset.
    always_comb begin
        wr_legal_s = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_legal_s = wr_legal_s |
                (wr_en && !rst && (wr_dest == ADDRESS_WIDTH'(r)) &&
                 !((ZERO_REG_EN != 0) && (r == 0)));
        end
    end

    // Next-state of the register array.
    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_legal_s && (wr_dest == ADDRESS_WIDTH'(r))) begin
                regs_d[r] = wr_data;
            end else begin
                regs_d[r] = regs_q[r];
            end
        end
    end

    // Register array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: array mux (unmatched addresses give 0), then write-through bypass.
    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_word_s[p] = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                rd_word_s[p] = rd_word_s[p] | (regs_q[r] & {DATA_WIDTH{
                    (rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ADDRESS_WIDTH'(r)) &&
                    !((ZERO_REG_EN != 0) && (r == 0))}});
            end
            if (rst) begin
                rd_word_s[p] = '0;
            end else if (wr_legal_s && (wr_dest == rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH])) begin
                rd_word_s[p] = wr_data;
            end else begin
                rd_word_s[p] = rd_word_s[p];
            end
        end
    end

    // Pack per-port words onto the flat output bus.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_word_s[p];
        end
    end

    // Store data formatting from read port 1 (already bypassed).
    always_comb begin
        fmt_s = decode_store_fmt(funct3, opcode);
        case (fmt_s)
            FMT_B:   st_data_s = {{(DATA_WIDTH-8){rd_word_s[1][7]}},   rd_word_s[1][7:0]};
            FMT_H:   st_data_s = {{(DATA_WIDTH-16){rd_word_s[1][15]}}, rd_word_s[1][15:0]};
            FMT_W:   st_data_s = rd_word_s[1];
            default: st_data_s = rd_word_s[1];
        endcase
    end

    assign st_data = st_data_s;

    regfile_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_REGS      (NUM_REGS),
        .NUM_RD_PORTS  (NUM_RD_PORTS),
        .ZERO_REG_EN   (ZERO_REG_EN)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_legal   (wr_legal_s),
        .wr_dest    (wr_dest),
        .set_en     (sb_set_en),
        .set_dest   (sb_set_dest),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;

    // Default configuration: 32 regs, 2 read ports
    logic        wr_en;
    logic [4:0]  wr_dest;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        sb_set_en;
    logic [4:0]  sb_set_dest;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic [31:0] st_data;
    logic [5:0]  busy_count;

    // Small configuration: 16 regs, 3 read ports
    logic        b_wr_en;
    logic [4:0]  b_wr_dest;
    logic [31:0] b_wr_data;
    logic [14:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic        b_sb_set_en;
    logic [4:0]  b_sb_set_dest;
    logic [2:0]  b_funct3;
    logic [6:0]  b_opcode;
    logic [31:0] b_st_data;
    logic [5:0]  b_busy_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .sb_set_en(sb_set_en), .sb_set_dest(sb_set_dest),
        .funct3(funct3), .opcode(opcode), .st_data(st_data), .busy_count(busy_count)
    );

    regfile_mp #(.NUM_REGS(16), .NUM_RD_PORTS(3)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_dest(b_wr_dest), .wr_data(b_wr_data),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .sb_set_en(b_sb_set_en), .sb_set_dest(b_sb_set_dest),
        .funct3(b_funct3), .opcode(b_opcode), .st_data(b_st_data), .busy_count(b_busy_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic        se;
        logic [4:0]  sd;
        logic [2:0]  f3;
        logic [6:0]  op;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_busy0;
        logic [31:0] e_st;
        logic [5:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [4:0] wd, input logic [31:0] wdata,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic se, input logic [4:0] sd,
                                input logic [2:0] f3, input logic [6:0] op,
                                input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                                input logic e_busy0, input logic [31:0] e_st, input logic [5:0] e_cnt);
        vec_t v;
        v.we = we; v.wd = wd; v.wdata = wdata; v.a0 = a0; v.a1 = a1;
        v.se = se; v.sd = sd; v.f3 = f3; v.op = op;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_busy0 = e_busy0; v.e_st = e_st; v.e_cnt = e_cnt;
        return v;
    endfunction

    // Reference model state (default configuration, register 0 hardwired)
    logic [31:0] m_regs [32];
    logic        m_busy [32];

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (wr_en && wr_dest != 5'd0 && wr_dest == a) return wr_data;
        if (a == 5'd0) return 32'd0;
        return m_regs[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        return m_busy[a] && !(wr_en && wr_dest != 5'd0 && wr_dest == a);
    endfunction

    function automatic logic [31:0] m_fmt(input logic [2:0] f3, input logic [6:0] op, input logic [31:0] d);
        if (op == 7'b0100011 && f3 == 3'd0) return {{24{d[7]}}, d[7:0]};
        if (op == 7'b0100011 && f3 == 3'd1) return {{16{d[15]}}, d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_count();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
        return 32'(c);
    endfunction

    task automatic idle_a();
        wr_en = 1'b0; wr_dest = 5'd0; wr_data = 32'd0; rd_addr = 10'd0;
        sb_set_en = 1'b0; sb_set_dest = 5'd0; funct3 = 3'd2; opcode = 7'h23;
    endtask

    task automatic idle_b();
        b_wr_en = 1'b0; b_wr_dest = 5'd0; b_wr_data = 32'd0; b_rd_addr = 15'd0;
        b_sb_set_en = 1'b0; b_sb_set_dest = 5'd0; b_funct3 = 3'd2; b_opcode = 7'h23;
    endtask

    vec_t vecs [13];
    logic [31:0] e0, e1, est;
    logic        eb0, eb1;

    initial begin
        vecs[0]  = mk(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 1'b0, 5'd0, 3'd2, 7'h23, 32'h12345678, 32'h0, 1'b0, 32'h0, 6'd0);
        vecs[1]  = mk(1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 5'd0, 3'd0, 7'h23, 32'h12345678, 32'h12345678, 1'b0, 32'h00000078, 6'd0);
        vecs[2]  = mk(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 3'd2, 7'h23, 32'h0, 32'h0, 1'b0, 32'h0, 6'd0);
        vecs[3]  = mk(1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd3, 3'd2, 7'h23, 32'h0, 32'h0, 1'b0, 32'h0, 6'd0);
        vecs[4]  = mk(1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 1'b0, 5'd0, 3'd1, 7'h23, 32'h0, 32'h12345678, 1'b1, 32'h00005678, 6'd1);
        vecs[5]  = mk(1'b1, 5'd3, 32'hAA,       5'd3, 5'd3, 1'b0, 5'd0, 3'd0, 7'h23, 32'hAA, 32'hAA, 1'b0, 32'hFFFFFFAA, 6'd1);
        vecs[6]  = mk(1'b1, 5'd4, 32'h55,       5'd4, 5'd9, 1'b1, 5'd4, 3'd2, 7'h23, 32'h55, 32'h0, 1'b0, 32'h0, 6'd0);
        vecs[7]  = mk(1'b1, 5'd9, 32'h000080F0, 5'd4, 5'd9, 1'b0, 5'd0, 3'd0, 7'h23, 32'h55, 32'h000080F0, 1'b1, 32'hFFFFFFF0, 6'd1);
        vecs[8]  = mk(1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b0, 5'd0, 3'd1, 7'h23, 32'h000080F0, 32'h000080F0, 1'b0, 32'hFFFF80F0, 6'd1);
        vecs[9]  = mk(1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b0, 5'd0, 3'd2, 7'h23, 32'h000080F0, 32'h000080F0, 1'b0, 32'h000080F0, 6'd1);
        vecs[10] = mk(1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b0, 5'd0, 3'd0, 7'h33, 32'h000080F0, 32'h000080F0, 1'b0, 32'h000080F0, 6'd1);
        vecs[11] = mk(1'b0, 5'd0, 32'h0,        5'd4, 5'd9, 1'b1, 5'd4, 3'd3, 7'h23, 32'h55, 32'h000080F0, 1'b1, 32'h000080F0, 6'd1);
        vecs[12] = mk(1'b0, 5'd0, 32'h0,        5'd4, 5'd9, 1'b0, 5'd0, 3'd2, 7'h23, 32'h55, 32'h000080F0, 1'b1, 32'h000080F0, 6'd1);

        idle_a();
        idle_b();
        rst = 1'b1;
        #1;
        check("reset_rd0", rd_data[31:0], 32'd0);
        check("reset_busy", 32'(rd_busy), 32'd0);
        check("reset_cnt", 32'(busy_count), 32'd0);
        check("reset_st", st_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_dest = vecs[i].wd; wr_data = vecs[i].wdata;
            rd_addr = {vecs[i].a1, vecs[i].a0};
            sb_set_en = vecs[i].se; sb_set_dest = vecs[i].sd;
            funct3 = vecs[i].f3; opcode = vecs[i].op;
            #2;
            check($sformatf("v%0d_rd0", i), rd_data[31:0], vecs[i].e_rd0);
            check($sformatf("v%0d_rd1", i), rd_data[63:32], vecs[i].e_rd1);
            check($sformatf("v%0d_busy0", i), 32'(rd_busy[0]), 32'(vecs[i].e_busy0));
            check($sformatf("v%0d_st", i), st_data, vecs[i].e_st);
            check($sformatf("v%0d_cnt", i), 32'(busy_count), 32'(vecs[i].e_cnt));
        end

        // Mid-cycle asynchronous reset
        @(negedge clk);
        idle_a();
        wr_en = 1'b1; wr_dest = 5'd5; wr_data = 32'hDEADBEEF;
        sb_set_en = 1'b1; sb_set_dest = 5'd6;
        @(negedge clk);
        idle_a();
        rd_addr = {5'd6, 5'd5};
        #1;
        check("pre_rst_rd5", rd_data[31:0], 32'hDEADBEEF);
        check("pre_rst_cnt", 32'(busy_count), 32'd2);
        check("pre_rst_busy6", 32'(rd_busy[1]), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_rd5", rd_data[31:0], 32'd0);
        check("mid_rst_cnt", 32'(busy_count), 32'd0);
        check("mid_rst_busy6", 32'(rd_busy[1]), 32'd0);
        #1;
        rst = 1'b0;

        // Small configuration: out-of-range address and three parallel reads
        @(negedge clk);
        b_wr_en = 1'b1; b_wr_dest = 5'd20; b_wr_data = 32'h11111111;
        b_sb_set_en = 1'b1; b_sb_set_dest = 5'd20;
        b_rd_addr = {5'd20, 5'd20, 5'd20};
        #2;
        check("b_oor_bypass", b_rd_data[31:0], 32'd0);
        @(negedge clk);
        idle_b();
        b_rd_addr = {5'd20, 5'd20, 5'd20};
        #2;
        check("b_oor_read", b_rd_data[95:64], 32'd0);
        check("b_oor_cnt", 32'(b_busy_count), 32'd0);
        check("b_oor_busy", 32'(b_rd_busy), 32'd0);
        @(negedge clk);
        b_wr_en = 1'b1; b_wr_dest = 5'd1;  b_wr_data = 32'hA1;
        @(negedge clk);
        b_wr_dest = 5'd2;  b_wr_data = 32'hB2;
        @(negedge clk);
        b_wr_dest = 5'd15; b_wr_data = 32'hCF;
        @(negedge clk);
        idle_b();
        b_rd_addr = {5'd15, 5'd2, 5'd1};
        #2;
        check("b_port0", b_rd_data[31:0], 32'hA1);
        check("b_port1", b_rd_data[63:32], 32'hB2);
        check("b_port2", b_rd_data[95:64], 32'hCF);
        check("b_st", b_st_data, 32'hB2);

        // Randomized run against the reference model
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'd0;
            m_busy[r] = 1'b0;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            wr_en       = 1'($urandom_range(0, 1));
            wr_dest     = 5'($urandom_range(0, 7));
            wr_data     = $urandom;
            rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            sb_set_en   = ($urandom_range(0, 2) == 0);
            sb_set_dest = 5'($urandom_range(0, 7));
            funct3      = 3'($urandom_range(0, 3));
            opcode      = ($urandom_range(0, 3) == 0) ? 7'h33 : 7'h23;
            #2;
            e0  = m_read(rd_addr[4:0]);
            e1  = m_read(rd_addr[9:5]);
            eb0 = m_rbusy(rd_addr[4:0]);
            eb1 = m_rbusy(rd_addr[9:5]);
            est = m_fmt(funct3, opcode, e1);
            check("rnd_rd0", rd_data[31:0], e0);
            check("rnd_rd1", rd_data[63:32], e1);
            check("rnd_busy", 32'(rd_busy), {30'd0, eb1, eb0});
            check("rnd_st", st_data, est);
            check("rnd_cnt", 32'(busy_count), m_count());
            if (wr_en && wr_dest != 5'd0) begin
                m_regs[wr_dest] = wr_data;
                m_busy[wr_dest] = 1'b0;
            end
            if (sb_set_en && sb_set_dest != 5'd0) m_busy[sb_set_dest] = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the pipelined core, generalising the current 2-read/1-write file.
- Adds:
  - posedge write with same-cycle write-through bypass
  - hardwired zero register
  - per-register pending-write scoreboard, used by the hazard unit to stall on outstanding load/long-latency producers
  - store-data formatting output for SB/SH/SW
- Sits between decode (read addresses, scoreboard set) and writeback (write port).

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDRESS_WIDTH, 5, register address bits.
- NUM_REGS, 32, number of registers (≤ 2^ADDRESS_WIDTH).
- NUM_RD_PORTS, 2, number of combinational read ports (≥ 2; port 1 feeds store formatting).
- ZERO_REG_EN, 1, 1 = register 0 reads 0, ignores writes, and is never marked busy.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  writeback write enable.
- wr_dest  in  ADDRESS_WIDTH  writeback destination.
- wr_data  in  DATA_WIDTH  writeback data.
- rd_addr  in  NUM_RD_PORTS*ADDRESS_WIDTH  packed read addresses, port p at [p*AW +: AW].
- rd_data  out  NUM_RD_PORTS*DATA_WIDTH  packed read data.
- rd_busy  out  NUM_RD_PORTS  1 = addressed register has a pending producer.
- sb_set_en  in  1  mark sb_set_dest pending (issue of load/long-latency op).
- sb_set_dest  in  ADDRESS_WIDTH  register to mark pending.
- funct3  in  3  instruction funct3 for store formatting.
- opcode  in  7  instruction opcode for store formatting.
- st_data  out  DATA_WIDTH  formatted store data derived from read port 1.
- busy_count  out  ADDRESS_WIDTH+1  number of registers currently marked pending.

Behaviour:
- Reset (async, rst=1): all registers = 0, all busy bits = 0, busy_count = 0. While rst is held, writes and sets are ignored.
  - Outputs during reset: rd_data = 0 for every port, rd_busy = 0, st_data = 0.
- Write: on posedge clk with wr_en=1, reg[wr_dest] <= wr_data.
  - Ignored if wr_dest ≥ NUM_REGS.
  - Ignored if ZERO_REG_EN=1 and wr_dest=0.
- Read (combinational, 0-cycle), per port p:
  - If wr_en && wr_dest==rd_addr[p] && the write is legal, rd_data[p] = wr_data (bypass).
  - Otherwise rd_data[p] = reg[rd_addr[p]].
  - Address ≥ NUM_REGS reads 0.
  - Register 0 reads 0 when ZERO_REG_EN=1.
- Scoreboard, per register r, on posedge:
  - set = sb_set_en && sb_set_dest==r.
  - clr = legal write to r.
  - set && clr → busy stays/becomes 1: new producer wins over completing producer.
  - clr only → 0.
  - set only → 1.
  - r=0 with ZERO_REG_EN=1 is never set.
- rd_busy[p] = busy[rd_addr[p]] && !(legal write to rd_addr[p] this cycle): the bypass resolves the hazard in the same cycle.
- busy_count: registered population count of busy bits, updated the same edge as the busy bits. Net change per cycle ∈ {-1, 0, +1}.
  - Set of an already-busy register with no clear → no change.
- Store formatting, with {funct3,opcode} and d = rd_data[1] after bypass:
  - 000_0100011 (SB): st_data = sign-extended d[7:0].
  - 001_0100011 (SH): st_data = sign-extended d[15:0].
  - 010_0100011 (SW) and all other codes: st_data = d.
- Latency: write visible on rd_data in the same cycle via bypass, and from the register array from the next cycle.
- Mid-operation reset: busy bits and count clear immediately, with no pending-write recovery.

Decomposition:
- Package regfile_pkg:
  - OPC_STORE = 7'b0100011
  - F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010
  - typedef store_fmt_e {FMT_B, FMT_H, FMT_W}
- One natural sub-module, regfile_scoreboard: busy bit vector, set/clear priority, busy_count register, rd_busy lookup.
- Array, bypass and store formatting stay in regfile_mp.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing reg5=0xDEADBEEF → rd_data for addr 5 = 0 immediately, busy_count = 0.
- Bypass: wr_en=1, wr_dest=7, wr_data=0x12345678, rd_addr port0=7 → rd_data0 = 0x12345678 the same cycle, and still 0x12345678 next cycle with wr_en=0.
- Zero register: write 0xFFFFFFFF to reg0 → port0 and port1 read 0 both in the write cycle and after. sb_set_en to reg0 → rd_busy = 0, busy_count unchanged.
- Scoreboard: set reg3, next cycle rd_busy for addr 3 = 1 and busy_count = 1.
  - Write reg3 with 0xAA → rd_busy = 0 in that cycle, busy_count = 0 after the edge.
  - Simultaneous set + write on reg4 → busy[4] = 1 after the edge.
- Store formatting: reg9 = 0x000080F0.
  - SB → st_data = 0xFFFFFFF0.
  - SH → st_data = 0xFFFF80F0.
  - SW → st_data = 0x000080F0.
  - Opcode 0110011 → st_data = 0x000080F0.
- Parametrisation: NUM_RD_PORTS=3, NUM_REGS=16. Read addr 20 → 0. Write to addr 20 → ignored, no busy change. All three ports read distinct registers correctly in the same cycle.
